imm_gen_pipe: RTL
=================

Name: imm_gen_pipe

Overview:
Pipelined, buffered RISC-V immediate generator for the decode stage. It accepts 32-bit instruction words over a valid/ready handshake and decodes the immediate for all base formats (I, S, B, U, J), sign-extended to XLEN. Results go into a small in-order FIFO and are presented to the execute stage with their format code over a second valid/ready handshake. It also supports a decode flush for branch redirect and keeps a saturating count of unsupported opcodes.

Parameters:
XLEN, 64, datapath width of the immediate output; legal values are 32 and 64.
DEPTH, 2, number of FIFO entries; must be a power of two and at least 2.
CNT_W, 8, width of the unsupported-opcode counter.

Ports:
clk  in  1  clock; everything is updated on its rising edge.
reset  in  1  asynchronous, active-high reset.
in_valid  in  1  the instruction word on in_instr is valid.
in_ready  out  1  the block can accept an instruction this cycle.
in_instr  in  32  instruction word.
flush  in  1  synchronous flush; discards all buffered entries.
out_valid  out  1  out_imm and out_fmt hold a valid entry.
out_ready  in  1  the consumer takes the head entry this cycle.
out_imm  out  XLEN  sign-extended immediate of the head entry.
out_fmt  out  3  format of the head entry: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J.
bad_cnt  out  CNT_W  saturating count of unsupported opcodes.

Behaviour:
- Reset is asynchronous and active-high. While reset is high: FIFO is empty; out_valid=0; out_imm=0; out_fmt=0; bad_cnt=0; in_ready=0. in_ready rises in the first cycle after reset is released.
- Reset asserted in the middle of traffic discards all entries immediately; no partial entry survives.
- Acceptance: an instruction is accepted when in_valid and in_ready are both 1 at a rising edge.
  - in_ready = !full && !reset.
  - Decode happens at accept time, and the decoded result is stored in the FIFO.
- Latency: an instruction accepted at edge N appears at the output (out_valid=1) after edge N. There is no combinational path from in_* to out_*.
- Pop: the head entry is removed when out_valid and out_ready are both 1 at a rising edge.
  - out_valid = (count != 0).
  - out_imm and out_fmt hold the head entry and stay stable while out_valid=1 and out_ready=0.
  - out_imm and out_fmt read 0 while the FIFO is empty.
- Simultaneous push and pop: the count is unchanged and order is preserved. When the FIFO is full, in_ready=0, so no push can occur in the same cycle as the pop; in_ready returns to 1 on the cycle after the pop.
- Pointers: read and write pointers wrap modulo DEPTH. The count saturates at DEPTH; overflow and underflow are impossible by construction.
- Flush: a synchronous flush empties the FIFO at the next edge. It has priority over push and pop at that edge, so any instruction presented in that cycle is dropped. bad_cnt is not changed by flush.
- Decode by opcode (in_instr[6:0]):
  - I format (fmt 1), opcodes 0000011, 0010011, 1100111: imm = sext(instr[31:20]).
  - S format (fmt 2), opcode 0100011: imm = sext({instr[31:25], instr[11:7]}).
  - B format (fmt 3), opcode 1100011: imm = sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}). This is the plain value; no shift is applied.
  - U format (fmt 4), opcodes 0110111, 0010111: imm = sext({instr[31:12], 12'b0}). For XLEN=32 no extension is needed.
  - J format (fmt 5), opcode 1101111: imm = sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - R type, opcode 0110011: fmt 0, imm 0, not counted.
  - Any other opcode: fmt 0, imm 0, and bad_cnt increments at accept time, saturating at all ones.
- Sign extension always replicates instr[31] up to bit XLEN-1.

Test Plan:
1. Reset release; push 0xFFC12083 (lw x1,-4(x2)) -> next cycle out_valid=1, out_fmt=1, out_imm=0xFFFFFFFFFFFFFFFC.
2. Push back-to-back with out_ready=1:
   - 0x00512423 -> fmt 2, imm 0x8.
   - 0xFE000CE3 -> fmt 3, imm 0xFFFFFFFFFFFFFFF8.
   - 0x123450B7 -> fmt 4, imm 0x0000000012345000.
   - 0xFFDFF06F -> fmt 5, imm 0xFFFFFFFFFFFFFFFC.
   Required: one result per cycle, in order.
3. Backpressure: hold out_ready=0 and push 3 instructions -> in_ready=0 after 2 accepts, the third is held. Raise out_ready -> results drain in order and in_ready rises the cycle after the first pop.
4. Push 0x00000033 and then 0x0000007F -> both give fmt 0 and imm 0; bad_cnt becomes 1. Push 0x7F 300 times -> bad_cnt saturates at 0xFF.
5. Fill the FIFO, then assert flush together with in_valid -> next cycle out_valid=0, count=0, the new instruction is dropped, and bad_cnt is unchanged.
6. Assert reset while the FIFO is full, between clock edges -> out_valid, out_imm, out_fmt, bad_cnt and in_ready go to 0 immediately. Repeat scenario 1 with XLEN=32 -> out_imm=0xFFFFFFFC.

Source files
------------

// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator for decode: decodes I/S/B/U/J immediates at accept
// time into a small in-order FIFO, with decode flush and a saturating bad-opcode count.
module imm_gen_pipe #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 2,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [2:0]       out_fmt,
    output logic [CNT_W-1:0] bad_cnt
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_REG    = 7'b0110011;

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;

    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic [CNT_W-1:0] r_bad_cnt;
    logic [XLEN-1:0]  r_imm_mem [DEPTH];
    logic [2:0]       r_fmt_mem [DEPTH];

    logic [31:0]      w_imm32;
    logic [XLEN-1:0]  w_imm;
    logic [2:0]       w_fmt;
    logic             w_bad;
    logic             w_full;
    logic             w_push;
    logic             w_pop;

    always_comb begin
        w_imm32 = '0;
        w_fmt   = FMT_NONE;
        w_bad   = 1'b0;
        case (in_instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                w_fmt   = FMT_I;
            end
            OP_STORE: begin
                w_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
                w_fmt   = FMT_S;
            end
            OP_BRANCH: begin
                w_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
                w_fmt   = FMT_B;
            end
            OP_LUI, OP_AUIPC: begin
                w_imm32 = {in_instr[31:12], 12'b0};
                w_fmt   = FMT_U;
            end
            OP_JAL: begin
                w_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                           in_instr[20], in_instr[30:21], 1'b0};
                w_fmt   = FMT_J;
            end
            OP_REG:  w_fmt = FMT_NONE;
            default: w_bad = 1'b1;
        endcase
    end

    // Bit 31 of the 32-bit immediate is always instr[31], so a signed widen is exact.
    assign w_imm = XLEN'($signed(w_imm32));

    assign w_full    = (r_count == (AW+1)'(DEPTH));
    assign in_ready  = !w_full && !reset;
    assign out_valid = (r_count != '0);
    assign w_push    = in_valid && in_ready && !flush;
    assign w_pop     = out_valid && out_ready && !flush;

    assign out_imm = out_valid ? r_imm_mem[r_rd_ptr] : '0;
    assign out_fmt = out_valid ? r_fmt_mem[r_rd_ptr] : FMT_NONE;
    assign bad_cnt = r_bad_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bad_cnt <= '0;
        end else if (w_push && w_bad && (r_bad_cnt != '1)) begin
            r_bad_cnt <= r_bad_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_imm_mem[r_wr_ptr] <= w_imm;
            r_fmt_mem[r_wr_ptr] <= w_fmt;
        end
    end

endmodule
